// File: rtl/dump_ctrl.sv
// Frame-window capture controller: arms on request, opens a dump window at a chosen frame count.
// Define DUMP_LOADROM_EN to hold arming in WAIT_DL until the ROM download finishes.
module dump_ctrl #(
    parameter int CW = 16
) (
    input  logic          rst_n,
    input  logic          clk,
    input  logic          vs,
    input  logic          dwnld,
    input  logic          arm,
    input  logic          abort,
    input  logic [CW-1:0] start_frame,
    input  logic [CW-1:0] num_frames,
    output logic [CW-1:0] frame_cnt,
    output logic          dump_en,
    output logic          dump_start,
    output logic          dump_stop,
    output logic          busy,
    output logic          done,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_DL = 3'd1,
        S_ARMED   = 3'd2,
        S_ACTIVE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

`ifdef DUMP_LOADROM_EN
    localparam state_t ARM_TARGET = S_WAIT_DL;
`else
    localparam state_t ARM_TARGET = S_ARMED;
`endif

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state;
    logic          vs_l;
    logic          dwnld_l;
    logic [CW-1:0] win_cnt;
    logic [CW-1:0] sf_q;
    logic [CW-1:0] nf_q;
    logic          vs_fall;
    logic          dwnld_fall;
    logic [CW-1:0] win_nxt;

    assign vs_fall    = vs_l & ~vs;
    assign dwnld_fall = dwnld_l & ~dwnld;
    assign win_nxt    = win_cnt + ONE;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_l      <= 1'b0;
            dwnld_l   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_l    <= vs;
            dwnld_l <= dwnld;
            if (vs_fall)
                frame_cnt <= frame_cnt + ONE;
        end
    end

    // Comparisons use frame_cnt before this edge's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            win_cnt    <= '0;
            sf_q       <= '0;
            nf_q       <= '0;
            dump_en    <= 1'b0;
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dump_start <= 1'b0;
            dump_stop  <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                dump_en   <= 1'b0;
                dump_stop <= (state == S_ACTIVE);
                busy      <= 1'b0;
                done      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            sf_q  <= start_frame;
                            nf_q  <= num_frames;
                            state <= ARM_TARGET;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                    S_WAIT_DL: begin
                        if (dwnld_fall)
                            state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (vs_fall && frame_cnt == sf_q) begin
                            state      <= S_ACTIVE;
                            win_cnt    <= '0;
                            dump_en    <= 1'b1;
                            dump_start <= 1'b1;
                        end
                    end
                    S_ACTIVE: begin
                        if (vs_fall) begin
                            if (nf_q != '0 && win_nxt == nf_q) begin
                                state     <= S_DONE;
                                dump_en   <= 1'b0;
                                dump_stop <= 1'b1;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                win_cnt <= win_nxt;
                            end
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        dump_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
